// File: rtl/i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter
// Function : Round-robin arbiter/sequencer sharing one byte-oriented I2C
//            master between NREQ client requesters.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter #(
    parameter int NREQ     = 4,
    parameter int IDW      = $clog2(NREQ),
    parameter int START_TO = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [40*NREQ-1:0]  req_data,
    input  logic [4*NREQ-1:0]   req_nbyte,
    output logic [NREQ-1:0]     gnt,
    output logic [IDW-1:0]      gnt_id,
    output logic [NREQ-1:0]     done,
    output logic [NREQ-1:0]     err,
    output logic [7:0]          rdata,
    output logic [NREQ-1:0]     rvalid,
    output logic                m_start,
    output logic [6:0]          m_addr,
    output logic                m_rw,
    output logic [39:0]         m_data_w,
    output logic [3:0]          m_N_byte,
    input  logic                m_busy,
    input  logic                m_erro_addr,
    input  logic [7:0]          m_data_out,
    input  logic                m_valid_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_ACTIVE    = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    // Terminal count is one below START_TO so done lands START_TO+1 cycles after m_start.
    localparam logic [7:0]     c_TO_LAST = 8'(START_TO - 1);
    localparam logic [IDW-1:0] c_LAST_ID = IDW'(NREQ - 1);

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [7:0]      r_timer;
    logic            r_sticky;
    logic [NREQ-1:0] r_gnt;
    logic [IDW-1:0]  r_gnt_id;
    logic [NREQ-1:0] r_done;
    logic [NREQ-1:0] r_err;
    logic [7:0]      r_rdata;
    logic [NREQ-1:0] r_rvalid;
    logic            r_m_start;
    logic [6:0]      r_m_addr;
    logic            r_m_rw;
    logic [39:0]     r_m_data_w;
    logic [3:0]      r_m_n_byte;

    logic            w_found;
    logic [IDW-1:0]  w_win;

    // Scan offsets from highest to lowest so the client nearest the pointer wins.
    always_comb begin : arb_comb
        logic [IDW:0]   v_sum;
        logic [IDW-1:0] v_idx;
        v_sum   = '0;
        v_idx   = '0;
        w_found = 1'b0;
        w_win   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            v_sum = {1'b0, r_ptr} + (IDW+1)'(i);
            if (v_sum >= (IDW+1)'(NREQ)) begin
                v_sum = v_sum - (IDW+1)'(NREQ);
            end
            v_idx = v_sum[IDW-1:0];
            if (req[v_idx]) begin
                w_found = 1'b1;
                w_win   = v_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_timer    <= '0;
            r_sticky   <= 1'b0;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_rvalid   <= '0;
            r_m_start  <= 1'b0;
            r_m_addr   <= '0;
            r_m_rw     <= 1'b0;
            r_m_data_w <= '0;
            r_m_n_byte <= '0;
        end else begin
            r_m_start <= 1'b0;
            r_done    <= '0;
            r_err     <= '0;
            r_rvalid  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found && !m_busy) begin
                        r_gnt      <= NREQ'(1) << w_win;
                        r_gnt_id   <= w_win;
                        r_m_addr   <= req_addr[7*w_win +: 7];
                        r_m_rw     <= req_rw[w_win];
                        r_m_data_w <= req_data[40*w_win +: 40];
                        r_m_n_byte <= req_nbyte[4*w_win +: 4];
                        r_m_start  <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (m_busy) begin
                        if (m_erro_addr) begin
                            r_sticky <= 1'b1;
                        end
                        r_state <= S_ACTIVE;
                    end else if (r_timer == c_TO_LAST) begin
                        r_done  <= r_gnt;
                        r_err   <= r_gnt;
                        r_state <= S_FINISH;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_ACTIVE: begin
                    if (m_valid_out) begin
                        r_rdata  <= m_data_out;
                        r_rvalid <= r_gnt;
                    end
                    // A NACK coinciding with the busy drop still counts.
                    if (!m_busy) begin
                        r_done  <= r_gnt;
                        r_err   <= (r_sticky || m_erro_addr) ? r_gnt : '0;
                        r_state <= S_FINISH;
                    end else if (m_erro_addr) begin
                        r_sticky <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_gnt    <= '0;
                    r_sticky <= 1'b0;
                    r_ptr    <= (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + IDW'(1);
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign gnt_id   = r_gnt_id;
    assign done     = r_done;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign m_start  = r_m_start;
    assign m_addr   = r_m_addr;
    assign m_rw     = r_m_rw;
    assign m_data_w = r_m_data_w;
    assign m_N_byte = r_m_n_byte;

endmodule
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Function : Directed self-checking bench for i2c_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int START_TO = 255;
    localparam logic [NREQ-1:0] c_ZERO_G = '0;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [7*NREQ-1:0]   req_addr;
    logic [NREQ-1:0]     req_rw;
    logic [40*NREQ-1:0]  req_data;
    logic [4*NREQ-1:0]   req_nbyte;
    logic [NREQ-1:0]     gnt;
    logic [IDW-1:0]      gnt_id;
    logic [NREQ-1:0]     done;
    logic [NREQ-1:0]     err;
    logic [7:0]          rdata;
    logic [NREQ-1:0]     rvalid;
    logic                m_start;
    logic [6:0]          m_addr;
    logic                m_rw;
    logic [39:0]         m_data_w;
    logic [3:0]          m_N_byte;
    logic                m_busy;
    logic                m_erro_addr;
    logic [7:0]          m_data_out;
    logic                m_valid_out;

    int total;
    int bad;

    i2c_req_arbiter #(
        .NREQ     (NREQ),
        .IDW      (IDW),
        .START_TO (START_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_addr    (req_addr),
        .req_rw      (req_rw),
        .req_data    (req_data),
        .req_nbyte   (req_nbyte),
        .gnt         (gnt),
        .gnt_id      (gnt_id),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .rvalid      (rvalid),
        .m_start     (m_start),
        .m_addr      (m_addr),
        .m_rw        (m_rw),
        .m_data_w    (m_data_w),
        .m_N_byte    (m_N_byte),
        .m_busy      (m_busy),
        .m_erro_addr (m_erro_addr),
        .m_data_out  (m_data_out),
        .m_valid_out (m_valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              client;
        logic [6:0]      addr;
        logic            rw;
        logic [39:0]     data;
        logic [3:0]      nbyte;
        int              busy_len;
        bit              nack;
        int              nrd;
        logic [23:0]     rbytes;
        bit              drop;
        logic [NREQ-1:0] exp_gnt;
        logic [NREQ-1:0] exp_err;
    } vec_t;

    vec_t vecs[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (m_start === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL wait_start: got no m_start expected pulse within 40 cycles");
        end
    endtask

    task automatic set_junk();
        for (int c = 0; c < NREQ; c++) begin
            req_addr[7*c +: 7]   = 7'(7'h60 + c);
            req_rw[c]            = c[0];
            req_data[40*c +: 40] = 40'hDEAD000000 + 40'(c);
            req_nbyte[4*c +: 4]  = 4'(9 + c);
        end
    endtask

    // Simple master: busy for busy_len cycles, read strobes every other cycle from k=2.
    task automatic serve(input int busy_len, input bit nack, input int nrd,
                         input logic [23:0] rbytes, input logic [NREQ-1:0] exp_g,
                         input logic [NREQ-1:0] exp_e);
        bit         strobe_prev;
        logic [7:0] byte_prev;
        int         j;
        strobe_prev = 1'b0;
        byte_prev   = '0;
        j           = 0;
        m_busy      = 1'b1;
        for (int k = 0; k < busy_len; k++) begin
            tick();
            m_valid_out = 1'b0;
            m_erro_addr = 1'b0;
            if (k == 0) chk("m_start_width", 64'(m_start), 64'd0);
            chk("gnt_hold", 64'(gnt), 64'(exp_g));
            chk("rvalid", 64'(rvalid), strobe_prev ? 64'(exp_g) : 64'(c_ZERO_G));
            if (strobe_prev) chk("rdata", 64'(rdata), 64'(byte_prev));
            strobe_prev = 1'b0;
            if (k >= 2 && (k % 2) == 0 && j < nrd) begin
                byte_prev   = rbytes[23 - 8*j -: 8];
                m_data_out  = byte_prev;
                m_valid_out = 1'b1;
                strobe_prev = 1'b1;
                j++;
            end
            if (nack && k == 2) m_erro_addr = 1'b1;
        end
        m_busy = 1'b0;
        tick();
        m_valid_out = 1'b0;
        m_erro_addr = 1'b0;
        chk("rvalid_last", 64'(rvalid), strobe_prev ? 64'(exp_g) : 64'(c_ZERO_G));
        if (strobe_prev) chk("rdata_last", 64'(rdata), 64'(byte_prev));
        chk("done", 64'(done), 64'(exp_g));
        chk("err", 64'(err), 64'(exp_e));
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit seen;
        bit flag;
        int rr_exp[4];

        total = 0;
        bad   = 0;
        rst = 1'b1;
        req = '0;
        req_addr = '0;
        req_rw = '0;
        req_data = '0;
        req_nbyte = '0;
        m_busy = 1'b0;
        m_erro_addr = 1'b0;
        m_data_out = '0;
        m_valid_out = 1'b0;

        vecs[0] = '{1, 7'h50, 1'b0, 40'h11223344AA, 4'd2,  20, 1'b0, 0, 24'h000000, 1'b0, 4'b0010, 4'b0000};
        vecs[1] = '{3, 7'h1E, 1'b0, 40'h0102030405, 4'd5,   6, 1'b1, 0, 24'h000000, 1'b0, 4'b1000, 4'b1000};
        vecs[2] = '{0, 7'h7F, 1'b1, 40'h0000000000, 4'd0,   2, 1'b0, 0, 24'h000000, 1'b0, 4'b0001, 4'b0000};
        vecs[3] = '{2, 7'h2A, 1'b1, 40'h0000000000, 4'd3,  10, 1'b0, 3, 24'hA55AFF, 1'b0, 4'b0100, 4'b0000};
        vecs[4] = '{1, 7'h00, 1'b0, 40'hFFFFFFFFFF, 4'd15,  4, 1'b0, 0, 24'h000000, 1'b1, 4'b0010, 4'b0000};

        tick();
        tick();
        chk("rst_gnt",      64'(gnt),      64'd0);
        chk("rst_gnt_id",   64'(gnt_id),   64'd0);
        chk("rst_done",     64'(done),     64'd0);
        chk("rst_err",      64'(err),      64'd0);
        chk("rst_rdata",    64'(rdata),    64'd0);
        chk("rst_rvalid",   64'(rvalid),   64'd0);
        chk("rst_m_start",  64'(m_start),  64'd0);
        chk("rst_m_addr",   64'(m_addr),   64'd0);
        chk("rst_m_rw",     64'(m_rw),     64'd0);
        chk("rst_m_data_w", 64'(m_data_w), 64'd0);
        chk("rst_m_N_byte", 64'(m_N_byte), 64'd0);
        rst = 1'b0;

        // Round robin with 0, 2, 3 requesting continuously; NACK on the second grant.
        set_junk();
        rr_exp = '{0, 2, 3, 0};
        req = 4'b1101;
        for (int r = 0; r < 4; r++) begin
            wait_start(seen);
            chk("rr_gnt_id", 64'(gnt_id), 64'(rr_exp[r]));
            chk("rr_gnt", 64'(gnt), 64'(4'b0001 << rr_exp[r]));
            serve((r == 1) ? 5 : 3, (r == 1), 0, 24'h0,
                  4'(4'b0001 << rr_exp[r]),
                  (r == 1) ? 4'(4'b0001 << rr_exp[r]) : 4'b0000);
            if (r == 3) req = '0;
        end
        tick();
        tick();

        // Single-client transactions from the vector table.
        for (int n = 0; n < 5; n++) begin
            set_junk();
            req_addr[7*vecs[n].client +: 7]   = vecs[n].addr;
            req_rw[vecs[n].client]            = vecs[n].rw;
            req_data[40*vecs[n].client +: 40] = vecs[n].data;
            req_nbyte[4*vecs[n].client +: 4]  = vecs[n].nbyte;
            req = '0;
            req[vecs[n].client] = 1'b1;
            wait_start(seen);
            chk("m_addr",   64'(m_addr),   64'(vecs[n].addr));
            chk("m_rw",     64'(m_rw),     64'(vecs[n].rw));
            chk("m_data_w", 64'(m_data_w), 64'(vecs[n].data));
            chk("m_N_byte", 64'(m_N_byte), 64'(vecs[n].nbyte));
            chk("gnt",      64'(gnt),      64'(vecs[n].exp_gnt));
            chk("gnt_id",   64'(gnt_id),   64'(vecs[n].client));
            if (vecs[n].drop) req = '0;
            serve(vecs[n].busy_len, vecs[n].nack, vecs[n].nrd, vecs[n].rbytes,
                  vecs[n].exp_gnt, vecs[n].exp_err);
            req = '0;
            tick();
            chk("done_width", 64'(done), 64'd0);
            chk("gnt_release", 64'(gnt), 64'd0);
            tick();
        end

        // Start timeout: busy never rises.
        set_junk();
        req = 4'b0010;
        wait_start(seen);
        flag = 1'b0;
        for (int i = 0; i < START_TO; i++) begin
            tick();
            if (done !== 4'b0000) flag = 1'b1;
        end
        chk("to_no_early_done", 64'(flag), 64'd0);
        tick();
        chk("to_done", 64'(done), 64'(4'b0010));
        chk("to_err",  64'(err),  64'(4'b0010));
        req = '0;
        tick();
        chk("to_idle_gnt", 64'(gnt), 64'd0);
        tick();

        // Reset mid-ACTIVE while the pointer sits at 2.
        req = 4'b1000;
        wait_start(seen);
        chk("pre_rst_gnt_id", 64'(gnt_id), 64'd3);
        m_busy = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_gnt",     64'(gnt),     64'd0);
        chk("midrst_m_start", 64'(m_start), 64'd0);
        chk("midrst_done",    64'(done),    64'd0);
        chk("midrst_gnt_id",  64'(gnt_id),  64'd0);
        chk("midrst_m_addr",  64'(m_addr),  64'd0);
        req = 4'b1010;
        flag = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done !== 4'b0000 || gnt !== 4'b0000) flag = 1'b1;
        end
        chk("midrst_quiet_while_busy", 64'(flag), 64'd0);
        m_busy = 1'b0;
        wait_start(seen);
        chk("midrst_ptr_zero", 64'(gnt_id), 64'd1);
        serve(2, 1'b0, 0, 24'h0, 4'b0010, 4'b0000);
        req = '0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
